// File: rtl/cpu_clock_ctrl_pkg.sv
// Shared types and constants for the CPU run/step clock controller.
package cpu_clock_ctrl_pkg;

   typedef enum logic [1:0] {
      M_HALT      = 2'd0,
      M_RUN       = 2'd1,
      M_STEP      = 2'd2,
      M_RUN_TO_BP = 2'd3
   } mode_e;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_HIGH    = 2'd1,
      S_LOW     = 2'd2,
      S_BP_HALT = 2'd3
   } state_e;

   localparam int PHASE_W = 16;

endpackage

// File: rtl/cpu_clock_ctrl_key_debounce.sv
// Step pushbutton conditioning: 2-flop synchronizer, level debounce, and a
// one-cycle press pulse on each accepted high-to-low transition.
module key_debounce #(
   parameter int DEB_CYCLES = 500000
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic key_n_i,
   output logic press_o
);

   localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

   logic          sync1_q, sync2_q;
   logic          deb_q, deb_d;
   logic          press_q;
   logic [CW-1:0] cnt_q, cnt_d;

   // Counter tracks consecutive samples that disagree with the accepted level.
   always_comb begin
      deb_d = deb_q;
      cnt_d = '0;
      if (sync2_q != deb_q) begin
         if (cnt_q == CNT_LAST) deb_d = sync2_q;
         else                   cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
         deb_q   <= 1'b1;
         cnt_q   <= '0;
         press_q <= 1'b0;
      end else begin
         sync1_q <= key_n_i;
         sync2_q <= sync1_q;
         deb_q   <= deb_d;
         cnt_q   <= cnt_d;
         press_q <= deb_q & ~deb_d;
      end
   end

   assign press_o = press_q;

endmodule

// File: rtl/cpu_clock_ctrl.sv
// Sequenced CPU clock generator: free run, debounced N-cycle step, and
// run-to-breakpoint on PC match, with status for LEDs / HEX mux.
module cpu_clock_ctrl
   import cpu_clock_ctrl_pkg::*;
#(
   parameter int DEB_CYCLES = 500000,
   parameter int CNT_W      = 16
) (
   input  logic             CLOCK_50,
   input  logic             reset_n,
   input  logic [1:0]       mode,
   input  logic [3:0]       div_sel,
   input  logic             step_key,
   input  logic [CNT_W-1:0] run_count,
   input  logic [31:0]      pc,
   input  logic [31:0]      bp_addr,
   output logic             clockCPU,
   output logic             cpu_busy,
   output logic             bp_hit,
   output logic [31:0]      cycle_count,
   output logic [1:0]       state
);

   state_e             state_q, state_d;
   logic [PHASE_W-1:0] phase_q, phase_d;
   logic [CNT_W-1:0]   rem_q, rem_d;
   logic [31:0]        cycle_q, cycle_d;
   logic               clk_q;

   mode_e              mode_w;
   logic               press;
   logic               decide, issue;
   logic [CNT_W-1:0]   avail;
   logic [CNT_W-1:0]   step_load;
   logic [PHASE_W-1:0] half_len;

   key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_key (
      .clk_i   (CLOCK_50),
      .rst_ni  (reset_n),
      .key_n_i (step_key),
      .press_o (press)
   );

   assign mode_w    = mode_e'(mode);
   assign step_load = (run_count == '0) ? CNT_W'(1) : run_count;
   // Phase length is sampled here each time a phase is entered.
   assign half_len  = (PHASE_W'(1) << div_sel) - PHASE_W'(1);

   always_comb begin
      state_d = state_q;
      phase_d = phase_q;
      rem_d   = rem_q;
      cycle_d = cycle_q;
      decide  = 1'b0;
      issue   = 1'b0;
      avail   = rem_q;
      case (state_q)
         S_IDLE: begin
            decide = 1'b1;
            if (press && mode_w == M_STEP) avail = step_load;
         end
         S_HIGH: begin
            if (phase_q == '0) begin
               state_d = S_LOW;
               phase_d = half_len;
            end else begin
               phase_d = phase_q - 1'b1;
            end
         end
         S_LOW: begin
            if (phase_q == '0) decide  = 1'b1;
            else               phase_d = phase_q - 1'b1;
         end
         S_BP_HALT: begin
            if (mode_w != M_RUN_TO_BP) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      if (decide) begin
         state_d = S_IDLE;
         phase_d = '0;
         if (mode_w != M_STEP) rem_d = '0;
         case (mode_w)
            M_RUN: issue = 1'b1;
            M_STEP: begin
               if (avail != '0) begin
                  issue = 1'b1;
                  rem_d = avail - 1'b1;
               end
            end
            // From IDLE the compare is skipped so a halted core can step off the BP.
            M_RUN_TO_BP: begin
               if (state_q == S_LOW && pc == bp_addr) state_d = S_BP_HALT;
               else                                   issue   = 1'b1;
            end
            default: ;
         endcase
         if (issue) begin
            state_d = S_HIGH;
            phase_d = half_len;
            cycle_d = cycle_q + 32'd1;
         end
      end
   end

   always_ff @(posedge CLOCK_50 or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
         phase_q <= '0;
         rem_q   <= '0;
         cycle_q <= '0;
         clk_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         phase_q <= phase_d;
         rem_q   <= rem_d;
         cycle_q <= cycle_d;
         clk_q   <= (state_d == S_HIGH);
      end
   end

   assign clockCPU    = clk_q;
   assign cpu_busy    = (state_q == S_HIGH) || (state_q == S_LOW);
   assign bp_hit      = (state_q == S_BP_HALT);
   assign cycle_count = cycle_q;
   assign state       = state_q;

endmodule

// File: doc/cpu_clock_ctrl.md
# cpu_clock_ctrl

Run/step controller that generates the CPU clock for the pipelined RV32 core on the DE-series board. It replaces ad-hoc clock toggling at the top level with a sequenced clock. Supported modes are free-run at a selectable divided rate, debounced N-cycle single-step from a pushbutton, and run-to-breakpoint on a PC match. It sits between the board clock and the CPU's `clockCPU` input and reports status for LEDs and the HEX display mux.

## Interface

Parameters:
- `DEB_CYCLES`, 500000: consecutive stable samples required to accept a key level change.
- `CNT_W`, 16: width of the step-count input and its internal counter.

Ports:
- `CLOCK_50` in 1: board clock; the only clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `mode` in 2: 00 HALT, 01 RUN, 10 STEP, 11 RUN_TO_BP.
- `div_sel` in 4: half-period of `clockCPU` is 2^div_sel `CLOCK_50` ticks.
- `step_key` in 1: raw pushbutton, active-low, asynchronous.
- `run_count` in CNT_W: number of CPU cycles issued per step press; 0 is treated as 1.
- `pc` in 32: current PC from the CPU.
- `bp_addr` in 32: breakpoint address.
- `clockCPU` out 1: registered CPU clock.
- `cpu_busy` out 1: 1 while a CPU cycle is in progress (HIGH or LOW state).
- `bp_hit` out 1: 1 while in BP_HALT.
- `cycle_count` out 32: count of `clockCPU` rising edges since reset; wraps at 2^32.
- `state` out 2: FSM state code for the LEDs.

## Operation

- FSM states: IDLE(0), HIGH(1), LOW(2), BP_HALT(3).
- One CPU cycle is HIGH for 2^div_sel ticks, then LOW for 2^div_sel ticks.
  - `clockCPU` = 1 exactly in HIGH.
  - `div_sel` is sampled at the start of each phase.
  - Phase counter is 16 bits and counts down to 0.
- Issue decision, taken in IDLE and at the terminal tick of LOW:
  - HALT: go to IDLE.
  - RUN: issue a cycle (go to HIGH).
  - STEP: issue if `remaining` > 0, decrementing `remaining` on each entry to HIGH; otherwise go to IDLE.
  - RUN_TO_BP at end of LOW: if `pc == bp_addr`, go to BP_HALT; else issue.
  - RUN_TO_BP from IDLE: always issue without comparing, so execution can leave a breakpoint address.
- Mode changes never truncate a phase. The current cycle always completes, and the new mode is applied at the next decision point.
- Step key path:
  - 2-flop synchronizer, then debounce counter. The debounced level updates only after DEB_CYCLES consecutive equal samples differing from it.
  - Press event = debounced 1→0 transition.
  - A press while in IDLE with mode = STEP loads `remaining` with max(run_count, 1).
  - Presses in any other state or mode are discarded, not queued.
- BP_HALT: hold `clockCPU` = 0 and `bp_hit` = 1. Leave to IDLE when `mode` != RUN_TO_BP; `bp_hit` clears on that transition.
- `cycle_count` increments on every entry to HIGH.
- `remaining` is cleared when mode leaves STEP at a decision point.

## Timing

- Reset (asynchronous, immediate):
  - `clockCPU` = 0, `state` = IDLE, `cpu_busy` = 0, `bp_hit` = 0, `cycle_count` = 0.
  - `remaining` = 0, phase counter = 0, debounced key = 1, synchronizer = 1.
- Reset asserted mid-HIGH drops `clockCPU` immediately. A truncated CPU cycle is acceptable because the CPU is reset by the same signal.
- Start latency: with `mode` = RUN in IDLE, `clockCPU` is 1 after the next `CLOCK_50` edge.
- Step latency: press event → `clockCPU` rises one edge later. Total from physical press is 2 sync cycles + DEB_CYCLES + 2 cycles.
- `pc` is compared at the terminal LOW tick, 2^div_sel ticks after the CPU edge, so it has settled.
- With `div_sel` = 0: `clockCPU` period = 2 ticks, 50% duty, back-to-back cycles with no idle gap.
- Breakpoint halt occurs after the CPU edge that produced the matching PC. `clockCPU` stays 0.

## Structure

- `cpu_clock_ctrl_pkg` holds:
  - mode enum: HALT, RUN, STEP, RUN_TO_BP.
  - FSM state enum, with codes matching the `state` port.
  - phase counter width constant (16).
- Sub-module `key_debounce`: synchronizer, debounce counter, and press-event output; parameter DEB_CYCLES.

## Test plan

- Reset mid-HIGH (RUN, div_sel=2): `clockCPU` drops to 0 asynchronously; `cycle_count` = 0; `state` = 0.
- RUN, div_sel=0, 20 ticks: 10 rising edges, period 2, `cycle_count` = 10. Switch to HALT mid-HIGH with div_sel=2: HIGH 4 ticks and LOW 4 ticks complete, then IDLE.
- STEP, DEB_CYCLES=4, run_count=3: key low for 10 ticks → exactly 3 edges, then IDLE. A 3-tick glitch → 0 edges. A second press while busy is ignored.
- STEP, run_count=0: one press → exactly 1 edge.
- RUN_TO_BP, bp_addr=0x10, PC model starts at 0 and adds 4 per `clockCPU` rise: halts after 4 edges, `bp_hit` = 1. Mode → HALT clears `bp_hit`. Re-entering RUN_TO_BP with pc=0x10 issues a cycle and runs on.
- `cycle_count` preloaded near wrap (via force) at 0xFFFFFFFF plus one edge → 0.
